// File: rtl/gon_issue_ctrl.sv
// rtl/gon_issue_ctrl.sv - GON X-bus packet issue controller: tagged packet FIFO with enable/ready retire
// Optional stall timeout enabled by defining GON_ISSUE_TIMEOUT_EN.
module gon_issue_ctrl #(
  parameter int DATA_WIDTH     = 64,
  parameter int ROW_TAG_WIDTH  = 4,
  parameter int COL_TAG_WIDTH  = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [ROW_TAG_WIDTH-1:0]      in_row_tag,
  input  logic [COL_TAG_WIDTH-1:0]      in_col_tag,
  output logic                          in_ready,
  output logic                          bus_enable,
  output logic [DATA_WIDTH-1:0]         bus_data,
  output logic [ROW_TAG_WIDTH-1:0]      bus_row_tag,
  output logic [COL_TAG_WIDTH-1:0]      bus_col_tag,
  input  logic                          bus_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   pkt_count,
  output logic                          err_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = DATA_WIDTH + ROW_TAG_WIDTH + COL_TAG_WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("gon_issue_ctrl: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic {IDLE, SEND} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, fire, pop, tmo;
  logic [PW-1:0]   head;

  assign in_ready   = (count_q != FULL_CNT);
  assign bus_enable = (state_q == SEND);
  assign head       = mem_q[rd_ptr_q];
  assign {bus_data, bus_row_tag, bus_col_tag} = bus_enable ? head : '0;
  assign pkt_count  = count_q;
  assign busy       = (count_q != '0) || bus_enable;

`ifdef GON_ISSUE_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT_CYCLES - 1);

  logic [SW-1:0] stall_q, stall_d;
  logic          err_q, err_d;

  // The last stalled cycle retires the head as a drop; flush wins over a coincident timeout.
  assign tmo = bus_enable && !bus_ready && !flush && (stall_q == STALL_MAX);

  always_comb begin
    stall_d = '0;
    err_d   = err_q | tmo;
    if (bus_enable && !pop && !flush) begin
      stall_d = stall_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign tmo         = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    push     = in_valid && in_ready;
    fire     = bus_enable && bus_ready;
    pop      = fire || tmo;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = IDLE;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {in_data, in_row_tag, in_col_tag};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      case (state_q)
        IDLE:    if (count_d != '0) state_d = SEND;
        SEND:    if (count_d == '0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_gon_issue_ctrl.sv
// tb/tb_gon_issue_ctrl.sv - randomized self-checking bench for gon_issue_ctrl against a queue model
module tb_gon_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, bus_ready;
  logic [63:0] in_data;
  logic [3:0]  in_row_tag, in_col_tag;
  logic        in_ready, bus_enable, busy, err_timeout;
  logic [63:0] bus_data;
  logic [3:0]  bus_row_tag, bus_col_tag;
  logic [2:0]  pkt_count;

  always #5 clk = ~clk;

  gon_issue_ctrl #(
    .DATA_WIDTH(64), .ROW_TAG_WIDTH(4), .COL_TAG_WIDTH(4), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_row_tag(in_row_tag), .in_col_tag(in_col_tag), .in_ready(in_ready),
    .bus_enable(bus_enable), .bus_data(bus_data), .bus_row_tag(bus_row_tag),
    .bus_col_tag(bus_col_tag), .bus_ready(bus_ready), .busy(busy),
    .pkt_count(pkt_count), .err_timeout(err_timeout)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  r;
    logic [3:0]  c;
  } pkt_t;

  pkt_t pq[$];
  bit   m_en;
  bit   m_err;
  int   m_stall;
  int   n_cmp;
  int   n_bad;
  pkt_t sent[8];

  function automatic pkt_t rand_pkt();
    pkt_t p;
    p.d = {$urandom, $urandom};
    p.r = 4'($urandom);
    p.c = 4'($urandom);
    return p;
  endfunction

  task automatic drive(input bit v, input pkt_t p);
    in_valid   = v;
    in_data    = p.d;
    in_row_tag = p.r;
    in_col_tag = p.c;
  endtask

  // Advance one clock; the model applies the packet-buffer rules to the inputs present this cycle.
  task automatic step();
    bit   push, fire, drop;
    pkt_t cur;
    cur  = '{d: in_data, r: in_row_tag, c: in_col_tag};
    push = in_valid && (pq.size() < DEPTH);
    fire = m_en && bus_ready;
    drop = 1'b0;
    if (!reset) begin
      pq.delete(); m_en = 1'b0; m_err = 1'b0; m_stall = 0;
    end else if (flush) begin
      pq.delete(); m_en = 1'b0; m_stall = 0;
    end else begin
`ifdef GON_ISSUE_TIMEOUT_EN
      if (m_en && !fire) begin
        m_stall++;
        if (m_stall == TMO) begin drop = 1'b1; m_stall = 0; m_err = 1'b1; end
      end else begin
        m_stall = 0;
      end
`endif
      if (fire || drop) void'(pq.pop_front());
      if (push) pq.push_back(cur);
      m_en = (pq.size() != 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; bus_ready = 1'b1;
    drive(1'b1, rand_pkt());
    step(); step();
    n_cmp++;
    if (bus_enable !== 1'b0 || pkt_count !== 3'd0 || busy !== 1'b0 || bus_data !== 64'd0 ||
        bus_row_tag !== 4'd0 || bus_col_tag !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: en=%b cnt=%0d busy=%b data=%h tags=%h/%h required all zero",
               bus_enable, pkt_count, busy, bus_data, bus_row_tag, bus_col_tag);
    end
    reset = 1'b1;
    drive(1'b0, '0);
    step();
    n_cmp++;
    if (in_ready !== 1'b1 || err_timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: in_ready=%b err=%b required 1/0", in_ready, err_timeout);
    end
  endtask

  task automatic test_single();
    pkt_t p;
    p = '{d: 64'hA5, r: 4'd1, c: 4'd3};
    bus_ready = 1'b1;
    drive(1'b1, p);
    step();
    drive(1'b0, '0);
    n_cmp++;
    if (bus_enable !== 1'b1 || bus_data !== 64'hA5 || bus_row_tag !== 4'd1 || bus_col_tag !== 4'd3 ||
        pkt_count !== 3'd1) begin
      n_bad++;
      $display("FAIL single_present: en=%b data=%h row=%0d col=%0d cnt=%0d required 1/a5/1/3/1",
               bus_enable, bus_data, bus_row_tag, bus_col_tag, pkt_count);
    end
    step();
    n_cmp++;
    if (bus_enable !== 1'b0 || pkt_count !== 3'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_retire: en=%b cnt=%0d busy=%b required 0/0/0", bus_enable, pkt_count, busy);
    end
  endtask

  task automatic fill4();
    bus_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      sent[i] = rand_pkt();
      drive(1'b1, sent[i]);
      step();
    end
  endtask

  task automatic test_fill();
    fill4();
    n_cmp++;
    if (in_ready !== 1'b0 || pkt_count !== 3'd4) begin
      n_bad++;
      $display("FAIL fill_full: in_ready=%b cnt=%0d required 0/4", in_ready, pkt_count);
    end
    drive(1'b1, rand_pkt());
    step();
    n_cmp++;
    if (pkt_count !== 3'd4) begin
      n_bad++;
      $display("FAIL fill_refuse: cnt=%0d required 4", pkt_count);
    end
    drive(1'b0, '0);
    bus_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (bus_enable !== 1'b1 || {bus_data, bus_row_tag, bus_col_tag} !== sent[i]) begin
        n_bad++;
        $display("FAIL fill_order[%0d]: en=%b pkt=%h required 1/%h", i, bus_enable,
                 {bus_data, bus_row_tag, bus_col_tag}, sent[i]);
      end
      step();
    end
    n_cmp++;
    if (bus_enable !== 1'b0 || pkt_count !== 3'd0) begin
      n_bad++;
      $display("FAIL fill_drained: en=%b cnt=%0d required 0/0", bus_enable, pkt_count);
    end
  endtask

  task automatic test_full_simul();
    pkt_t x, y;
    fill4();
    x = rand_pkt();
    y = rand_pkt();
    bus_ready = 1'b1;
    drive(1'b1, x);
    step();
    n_cmp++;
    if (pkt_count !== 3'd3) begin
      n_bad++;
      $display("FAIL full_simul_refuse: cnt=%0d required 3", pkt_count);
    end
    drive(1'b1, y);
    step();
    drive(1'b0, '0);
    n_cmp++;
    if (pkt_count !== 3'd3 || bus_data !== sent[2].d) begin
      n_bad++;
      $display("FAIL full_simul_keep: cnt=%0d data=%h required 3/%h", pkt_count, bus_data, sent[2].d);
    end
    sent[4] = y;
    for (int i = 2; i < 5; i++) begin
      if (i == 4) begin
        n_cmp++;
        if ({bus_data, bus_row_tag, bus_col_tag} !== y) begin
          n_bad++;
          $display("FAIL full_simul_tail: pkt=%h required %h", {bus_data, bus_row_tag, bus_col_tag}, y);
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int idx;
    bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sent[i] = rand_pkt();
      drive(1'b1, sent[i]);
      step();
    end
    drive(1'b0, '0);
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      bus_ready = k[0];
      n_cmp++;
      if (bus_enable !== 1'b1 || bus_data !== sent[idx].d) begin
        n_bad++;
        $display("FAIL backpressure[%0d]: en=%b data=%h required 1/%h", k, bus_enable, bus_data, sent[idx].d);
      end
      step();
      if (k[0]) idx++;
    end
    n_cmp++;
    if (pkt_count !== 3'd0 || bus_enable !== 1'b0) begin
      n_bad++;
      $display("FAIL backpressure_end: cnt=%0d en=%b required 0/0", pkt_count, bus_enable);
    end
  endtask

  task automatic test_flush();
    bus_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin drive(1'b1, rand_pkt()); step(); end
    flush = 1'b1;
    drive(1'b1, rand_pkt());
    step();
    flush = 1'b0;
    drive(1'b0, '0);
    n_cmp++;
    if (pkt_count !== 3'd0 || bus_enable !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_clear: cnt=%0d en=%b required 0/0", pkt_count, bus_enable);
    end
    step();
    n_cmp++;
    if (pkt_count !== 3'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_drop_push: cnt=%0d busy=%b required 0/0", pkt_count, busy);
    end
  endtask

  task automatic test_reset_mid();
    bus_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin drive(1'b1, rand_pkt()); step(); end
    drive(1'b0, '0);
    reset = 1'b0;
    step();
    n_cmp++;
    if (bus_enable !== 1'b0 || bus_data !== 64'd0 || bus_row_tag !== 4'd0 || bus_col_tag !== 4'd0 ||
        pkt_count !== 3'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: en=%b data=%h cnt=%0d busy=%b required all zero", bus_enable, bus_data,
               pkt_count, busy);
    end
    reset = 1'b1;
    step();
  endtask

`ifdef GON_ISSUE_TIMEOUT_EN
  task automatic test_timeout();
    bus_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin sent[i] = rand_pkt(); drive(1'b1, sent[i]); step(); end
    drive(1'b0, '0);
    for (int i = 0; i < TMO - 2; i++) step();
    n_cmp++;
    if (err_timeout !== 1'b0 || bus_data !== sent[0].d) begin
      n_bad++;
      $display("FAIL timeout_early: err=%b data=%h required 0/%h", err_timeout, bus_data, sent[0].d);
    end
    step();
    n_cmp++;
    if (err_timeout !== 1'b1 || bus_data !== sent[1].d || pkt_count !== 3'd1) begin
      n_bad++;
      $display("FAIL timeout_drop: err=%b data=%h cnt=%0d required 1/%h/1", err_timeout, bus_data,
               pkt_count, sent[1].d);
    end
    bus_ready = 1'b1;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++;
    if (err_timeout !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_sticky: err=%b required 1", err_timeout);
    end
  endtask
`endif

  task automatic test_random();
    logic [63:0] ed;
    logic [3:0]  er, ec;
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 2) != 0, rand_pkt());
      bus_ready = (k < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 40) == 0);
      ed = m_en ? pq[0].d : 64'd0;
      er = m_en ? pq[0].r : 4'd0;
      ec = m_en ? pq[0].c : 4'd0;
      n_cmp++;
      if (bus_enable !== m_en || bus_data !== ed || bus_row_tag !== er || bus_col_tag !== ec ||
          pkt_count !== 3'(pq.size()) || in_ready !== (pq.size() != DEPTH) ||
          busy !== (pq.size() != 0 || m_en) || err_timeout !== m_err) begin
        n_bad++;
        $display("FAIL random[%0d]: en=%b data=%h tags=%h/%h cnt=%0d rdy=%b busy=%b err=%b required %b/%h/%h/%h/%0d/%b/%b/%b",
                 k, bus_enable, bus_data, bus_row_tag, bus_col_tag, pkt_count, in_ready, busy, err_timeout,
                 m_en, ed, er, ec, pq.size(), pq.size() != DEPTH, pq.size() != 0 || m_en, m_err);
      end
      step();
    end
    flush = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; m_en = 1'b0; m_err = 1'b0; m_stall = 0;
    reset = 1'b0; flush = 1'b0; bus_ready = 1'b0;
    drive(1'b0, '0);
    #1;
    test_reset();
    test_single();
    test_fill();
    test_full_simul();
    test_backpressure();
    test_flush();
    test_reset_mid();
`ifdef GON_ISSUE_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
